// File: rtl/condlogic_it.sv
// ARM conditional-logic block: NZCV flag register, condition evaluation and strobe gating,
// extended with a Thumb-style IT sequencer and Stall/Flush handling.
module condlogic_it #(
    parameter int unsigned ITDEPTH     = 4,
    parameter logic [3:0]  FLAGS_RESET = 4'b0000,
    parameter int unsigned LW          = $clog2(ITDEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [3:0]         ALUFlags,
    input  logic [1:0]         FlagW,
    input  logic               PCS,
    input  logic               RegW,
    input  logic               MemW,
    input  logic               NoWrite,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               ITStart,
    input  logic [3:0]         ITCond,
    input  logic [LW-1:0]      ITLen,
    input  logic [ITDEPTH-1:0] ITMask,
    output logic               PCSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               CondEx,
    output logic [3:0]         Flags,
    output logic               ITActive,
    output logic [LW-1:0]      ITCount,
    output logic               ITErr
);

    localparam logic [LW-1:0]      MAX_LEN = LW'(ITDEPTH);
    localparam logic [LW-1:0]      ONE_LEN = LW'(1);
    localparam logic [ITDEPTH-1:0] SLOT0   = ITDEPTH'(1);

    typedef enum logic {StIdle, StActive} it_state_e;

    it_state_e          state_q;
    logic [3:0]         flags_q;
    logic [3:0]         itcond_q;
    logic [ITDEPTH-1:0] mask_q;
    logic [LW-1:0]      count_q;
    logic               iterr_q;

    logic [3:0] ec;
    logic       n, z, c, v;
    logic       kill;
    logic       len_ok;

    assign n = flags_q[3];
    assign z = flags_q[2];
    assign c = flags_q[1];
    assign v = flags_q[0];

    // Inside an IT block the low condition bit is flipped for else-slots.
    assign ec = (state_q == StActive) ? {itcond_q[3:1], itcond_q[0] ^ ~mask_q[0]} : Cond;

    always_comb begin
        CondEx = 1'b0;
        case (ec)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    assign kill   = Stall | Flush | reset | ITStart;
    assign len_ok = (ITLen != '0) && (ITLen <= MAX_LEN);

    assign RegWrite = RegW & CondEx & ~NoWrite & ~kill;
    assign MemWrite = MemW & CondEx & ~kill;
    assign PCSrc    = PCS & CondEx & ~kill;

    assign Flags    = flags_q;
    assign ITActive = (state_q == StActive);
    assign ITCount  = count_q;
    assign ITErr    = iterr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            flags_q  <= FLAGS_RESET;
            itcond_q <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            iterr_q  <= 1'b0;
        end else if (Flush) begin
            // Flush overrides Stall, ITStart and slot consumption; the instruction is killed.
            state_q  <= StIdle;
            itcond_q <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            iterr_q  <= 1'b0;
        end else if (!Stall) begin
            iterr_q <= 1'b0;
            if (FlagW[1] && CondEx && !kill) begin
                flags_q[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0] && CondEx && !kill) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
            case (state_q)
                StIdle: begin
                    if (ITStart) begin
                        if (len_ok) begin
                            state_q  <= StActive;
                            itcond_q <= ITCond;
                            mask_q   <= ITMask | SLOT0;
                            count_q  <= ITLen;
                        end else begin
                            iterr_q <= 1'b1;
                        end
                    end
                end
                StActive: begin
                    // Nested IT is killed but still consumes its slot.
                    if (ITStart) begin
                        iterr_q <= 1'b1;
                    end
                    // A taken branch ends the block early so no stale slots linger.
                    if ((count_q == ONE_LEN) || PCSrc) begin
                        state_q  <= StIdle;
                        itcond_q <= '0;
                        mask_q   <= '0;
                        count_q  <= '0;
                    end else begin
                        count_q <= count_q - ONE_LEN;
                        mask_q  <= mask_q >> 1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_condlogic_it.sv
// Randomised and directed bench for condlogic_it: a queue-of-slot-conditions reference model
// pushes expected outputs each cycle; a negedge monitor pops and compares them.
module tb_condlogic_it;

    localparam int unsigned ITDEPTH     = 4;
    localparam int unsigned LW          = $clog2(ITDEPTH) + 1;
    localparam logic [3:0]  FLAGS_RESET = 4'b0000;

    logic               clk;
    logic               reset;
    logic [3:0]         Cond;
    logic [3:0]         ALUFlags;
    logic [1:0]         FlagW;
    logic               PCS, RegW, MemW, NoWrite, Stall, Flush, ITStart;
    logic [3:0]         ITCond;
    logic [LW-1:0]      ITLen;
    logic [ITDEPTH-1:0] ITMask;
    logic               PCSrc, RegWrite, MemWrite, CondEx, ITActive, ITErr;
    logic [3:0]         Flags;
    logic [LW-1:0]      ITCount;

    condlogic_it #(
        .ITDEPTH     (ITDEPTH),
        .FLAGS_RESET (FLAGS_RESET)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .Stall    (Stall),
        .Flush    (Flush),
        .ITStart  (ITStart),
        .ITCond   (ITCond),
        .ITLen    (ITLen),
        .ITMask   (ITMask),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags),
        .ITActive (ITActive),
        .ITCount  (ITCount),
        .ITErr    (ITErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               rst;
        logic [3:0]         cond;
        logic [3:0]         alu;
        logic [1:0]         fw;
        logic               pcs, regw, memw, nowr, stall, flush, its;
        logic [3:0]         itc;
        logic [LW-1:0]      itl;
        logic [ITDEPTH-1:0] itm;
    } stim_t;

    typedef struct {
        logic          pcsrc, regwrite, memwrite, condex;
        logic [3:0]    flags;
        logic          itactive;
        logic [LW-1:0] itcount;
        logic          iterr;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_flags;
    logic [3:0] m_slots[$];  // condition code of each remaining IT slot, oldest first
    logic       m_err;
    int         n_checks = 0;
    int         n_pass   = 0;

    // Pairwise ARM decode: even code is the base test, odd code its negation.
    function automatic logic cond_holds(input logic [3:0] ec, input logic [3:0] f);
        logic base;
        case (ec[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] && !f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = !f[2] && (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        if (ec == 4'b1111) return 1'b0;
        return base ^ ec[0];
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s.rst = 1'b0; s.cond = 4'b1110; s.alu = 4'b0000; s.fw = 2'b00;
        s.pcs = 1'b0; s.regw = 1'b0; s.memw = 1'b0; s.nowr = 1'b0;
        s.stall = 1'b0; s.flush = 1'b0; s.its = 1'b0;
        s.itc = 4'b0000; s.itl = '0; s.itm = '0;
        return s;
    endfunction

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, req);
    endtask

    task automatic apply(input stim_t s);
        exp_t       e;
        logic [3:0] ec;
        logic       cx, kill, len_ok;
        reset = s.rst; Cond = s.cond; ALUFlags = s.alu; FlagW = s.fw;
        PCS = s.pcs; RegW = s.regw; MemW = s.memw; NoWrite = s.nowr;
        Stall = s.stall; Flush = s.flush; ITStart = s.its;
        ITCond = s.itc; ITLen = s.itl; ITMask = s.itm;

        ec   = (m_slots.size() > 0) ? m_slots[0] : s.cond;
        cx   = cond_holds(ec, m_flags);
        kill = s.stall || s.flush || s.rst || s.its;
        e.condex   = cx;
        e.regwrite = s.regw && cx && !s.nowr && !kill;
        e.memwrite = s.memw && cx && !kill;
        e.pcsrc    = s.pcs && cx && !kill;
        e.flags    = m_flags;
        e.itactive = (m_slots.size() > 0);
        e.itcount  = LW'(m_slots.size());
        e.iterr    = m_err;
        sb.push_back(e);

        len_ok = (int'(s.itl) >= 1) && (int'(s.itl) <= int'(ITDEPTH));
        if (s.rst) begin
            m_flags = FLAGS_RESET;
            m_slots.delete();
            m_err = 1'b0;
        end else if (s.flush) begin
            m_slots.delete();
            m_err = 1'b0;
        end else if (!s.stall) begin
            if (s.fw[1] && cx && !kill) m_flags[3:2] = s.alu[3:2];
            if (s.fw[0] && cx && !kill) m_flags[1:0] = s.alu[1:0];
            if (m_slots.size() > 0) begin
                m_err = s.its;
                void'(m_slots.pop_front());
                if (e.pcsrc) m_slots.delete();
            end else begin
                m_err = s.its && !len_ok;
                if (s.its && len_ok) begin
                    for (int k = 0; k < int'(s.itl); k++) begin
                        m_slots.push_back((k == 0 || s.itm[k]) ? s.itc : (s.itc ^ 4'b0001));
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check1("PCSrc",    {7'd0, PCSrc},    {7'd0, e.pcsrc});
            check1("RegWrite", {7'd0, RegWrite}, {7'd0, e.regwrite});
            check1("MemWrite", {7'd0, MemWrite}, {7'd0, e.memwrite});
            check1("CondEx",   {7'd0, CondEx},   {7'd0, e.condex});
            check1("Flags",    {4'd0, Flags},    {4'd0, e.flags});
            check1("ITActive", {7'd0, ITActive}, {7'd0, e.itactive});
            check1("ITCount",  8'(ITCount),      8'(e.itcount));
            check1("ITErr",    {7'd0, ITErr},    {7'd0, e.iterr});
        end
    end

    initial begin
        stim_t s;
        m_flags = FLAGS_RESET;
        m_err   = 1'b0;
        s = nop(); s.rst = 1'b1;
        reset = 1'b1; Cond = 4'b1110; ALUFlags = '0; FlagW = '0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; Stall = 0; Flush = 0; ITStart = 0;
        ITCond = '0; ITLen = '0; ITMask = '0;
        @(posedge clk);
        #1;
        s.regw = 1'b1; s.memw = 1'b1; s.pcs = 1'b1;
        apply(s);
        apply(s);

        // Flag write, then EQ/NE against the new Z
        s = nop(); s.alu = 4'b0100; s.fw = 2'b11; apply(s);
        s = nop(); s.cond = 4'b0000; s.regw = 1'b1; apply(s);
        s.cond = 4'b0001; apply(s);

        // IT EQ, T E T
        s = nop(); s.its = 1'b1; s.itc = 4'b0000; s.itl = LW'(3); s.itm = 4'b0101; apply(s);
        s = nop(); s.regw = 1'b1; s.cond = 4'b0001;
        repeat (4) apply(s);

        // Flag latency: first slot clears Z, second slot must fail
        s = nop(); s.its = 1'b1; s.itc = 4'b0000; s.itl = LW'(2); s.itm = 4'b0011; apply(s);
        s = nop(); s.regw = 1'b1; s.fw = 2'b10; s.alu = 4'b0000; apply(s);
        s = nop(); s.regw = 1'b1; apply(s);
        s = nop(); s.alu = 4'b0100; s.fw = 2'b11; apply(s);

        // Stall for 3 cycles during slot 2 of 4
        s = nop(); s.its = 1'b1; s.itc = 4'b0000; s.itl = LW'(4); s.itm = 4'b1111; apply(s);
        s = nop(); s.regw = 1'b1; apply(s);
        s.stall = 1'b1; s.fw = 2'b11; s.alu = 4'b0000;
        repeat (3) apply(s);
        s = nop(); s.regw = 1'b1; s.memw = 1'b1;
        repeat (4) apply(s);

        // Flush during slot 2 of 4, then own Cond again
        s = nop(); s.its = 1'b1; s.itc = 4'b0000; s.itl = LW'(4); s.itm = 4'b1111; apply(s);
        s = nop(); s.regw = 1'b1; apply(s);
        s.flush = 1'b1; apply(s);
        s = nop(); s.regw = 1'b1; s.cond = 4'b0001; apply(s);
        s.cond = 4'b0000; apply(s);

        // Illegal IT requests: length 0, length ITDEPTH+1, nested
        s = nop(); s.its = 1'b1; s.itl = '0; apply(s);
        s = nop(); apply(s); apply(s);
        s = nop(); s.its = 1'b1; s.itl = LW'(ITDEPTH + 1); apply(s);
        s = nop(); apply(s); apply(s);
        s = nop(); s.its = 1'b1; s.itc = 4'b0000; s.itl = LW'(3); s.itm = 4'b0111; apply(s);
        s = nop(); s.regw = 1'b1; apply(s);
        s.its = 1'b1; s.itl = LW'(2); apply(s);
        s = nop(); s.regw = 1'b1; repeat (3) apply(s);

        // EC = 1111 both directly and as the else-slot of AL
        s = nop(); s.cond = 4'b1111; s.regw = 1'b1; apply(s);
        s = nop(); s.its = 1'b1; s.itc = 4'b1110; s.itl = LW'(2); s.itm = 4'b0001; apply(s);
        s = nop(); s.regw = 1'b1; repeat (3) apply(s);

        // Branch mid-block aborts; reset mid-block discards slots
        s = nop(); s.its = 1'b1; s.itc = 4'b0000; s.itl = LW'(3); s.itm = 4'b0111; apply(s);
        s = nop(); s.pcs = 1'b1; apply(s);
        s = nop(); s.regw = 1'b1; s.cond = 4'b0001; apply(s);
        s = nop(); s.its = 1'b1; s.itc = 4'b0000; s.itl = LW'(4); s.itm = 4'b1111; apply(s);
        s = nop(); s.rst = 1'b1; apply(s);
        s = nop(); s.regw = 1'b1; apply(s); apply(s);

        for (int i = 0; i < 1500; i++) begin
            s.rst   = ($urandom_range(0, 99) == 0);
            s.cond  = 4'($urandom);
            s.alu   = 4'($urandom);
            s.fw    = 2'($urandom);
            s.pcs   = ($urandom_range(0, 7) == 0);
            s.regw  = 1'($urandom);
            s.memw  = 1'($urandom);
            s.nowr  = ($urandom_range(0, 3) == 0);
            s.stall = ($urandom_range(0, 5) == 0);
            s.flush = ($urandom_range(0, 15) == 0);
            s.its   = ($urandom_range(0, 5) == 0);
            s.itc   = 4'($urandom);
            s.itl   = LW'($urandom_range(0, ITDEPTH + 1));
            s.itm   = ITDEPTH'($urandom);
            apply(s);
        end

        @(negedge clk);
        #1;
        check1("scoreboard_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
